// File: rtl/octet_dispatcher.sv
// octet_dispatcher: drives one Octet compute unit with one operand tile at a time.
//
// Collects a tile of T = C_BEATS beats from the upstream stream into staging registers, starts
// the Octet once it is idle and the result FIFO can absorb a whole tile, feeds beat j on the
// operand buses during the j-th fetch cycle, pulses fetch_done, then captures write-back beats
// into a result FIFO that drains through a valid/ready stream.
//
// Ports:
//   clk, rstn                 clock; synchronous active-high reset (rstn=1 resets)
//   in_valid/in_ready         upstream beat handshake; in_a/in_b/in_c beat payload
//   oct_idle/fetch/compute/write_back, oct_result   Octet status and result_out
//   oct_start, oct_fetch_done single-cycle registered pulses to the Octet
//   oct_a/oct_b/oct_c         registered operand buses to the Octet
//   out_valid/out_ready/out_data   result stream (FIFO head)
//   busy                      high in every state except LOAD
//   wb_error                  sticky fetch/write-back protocol error
module octet_dispatcher #(
  parameter int unsigned A_DATA_WIDTH   = 128,
  parameter int unsigned B_DATA_WIDTH   = 64,
  parameter int unsigned C_DATA_WIDTH   = 128,
  parameter int unsigned A_BEATS        = 2,
  parameter int unsigned B_BEATS        = 4,
  parameter int unsigned C_BEATS        = 8,
  parameter int unsigned RES_FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [A_DATA_WIDTH-1:0] in_a,
  input  logic [B_DATA_WIDTH-1:0] in_b,
  input  logic [C_DATA_WIDTH-1:0] in_c,
  input  logic                    oct_idle,
  input  logic                    oct_fetch,
  input  logic                    oct_compute,
  input  logic                    oct_write_back,
  input  logic [C_DATA_WIDTH-1:0] oct_result,
  output logic                    oct_start,
  output logic                    oct_fetch_done,
  output logic [A_DATA_WIDTH-1:0] oct_a,
  output logic [B_DATA_WIDTH-1:0] oct_b,
  output logic [C_DATA_WIDTH-1:0] oct_c,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [C_DATA_WIDTH-1:0] out_data,
  output logic                    busy,
  output logic                    wb_error
);

  localparam int unsigned KW = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
  localparam int unsigned PW = (RES_FIFO_DEPTH > 1) ? $clog2(RES_FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RES_FIFO_DEPTH + 1);
  localparam int unsigned WW = $clog2(C_BEATS + 1);

  typedef enum logic [2:0] {
    StLoad, StArm, StStart, StWaitFetch, StFetch, StDone, StDrain
  } state_e;

  state_e                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [KW-1:0]           j_q, j_d;
  logic [WW-1:0]           wb_cnt_q, wb_cnt_d;
  logic                    wb_error_q, wb_error_d;
  logic                    start_q, start_d;
  logic                    fetch_done_q, fetch_done_d;
  logic [A_DATA_WIDTH-1:0] oct_a_q, oct_a_d;
  logic [B_DATA_WIDTH-1:0] oct_b_q, oct_b_d;
  logic [C_DATA_WIDTH-1:0] oct_c_q, oct_c_d;

  logic [A_DATA_WIDTH-1:0] a_q [A_BEATS];
  logic [A_DATA_WIDTH-1:0] a_d [A_BEATS];
  logic [B_DATA_WIDTH-1:0] b_q [B_BEATS];
  logic [B_DATA_WIDTH-1:0] b_d [B_BEATS];
  logic [C_DATA_WIDTH-1:0] c_q [C_BEATS];
  logic [C_DATA_WIDTH-1:0] c_d [C_BEATS];

  logic [C_DATA_WIDTH-1:0] mem_q [RES_FIFO_DEPTH];
  logic [C_DATA_WIDTH-1:0] mem_d [RES_FIFO_DEPTH];
  logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]           count_q, count_d;

  logic                    push, pop, fifo_full, room_ok;
  logic                    bus_en;
  logic [KW-1:0]           bus_idx, cur_j;
  logic [A_DATA_WIDTH-1:0] beat_a;
  logic [B_DATA_WIDTH-1:0] beat_b;
  logic [C_DATA_WIDTH-1:0] beat_c;

  // The compute phase needs no action from the dispatcher.
  logic unused_status;
  assign unused_status = oct_compute;

  assign fifo_full = (count_q == CW'(RES_FIFO_DEPTH));
  assign room_ok   = (count_q <= CW'(RES_FIFO_DEPTH - C_BEATS));
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rptr_q];
  assign pop       = out_valid && out_ready;

  // Beat bus_idx of the staged tile; A and B are zero past their own beat counts.
  always_comb begin
    beat_a = '0;
    beat_b = '0;
    beat_c = '0;
    for (int i = 0; i < int'(A_BEATS); i++) if (bus_idx == KW'(i)) beat_a = a_q[i];
    for (int i = 0; i < int'(B_BEATS); i++) if (bus_idx == KW'(i)) beat_b = b_q[i];
    for (int i = 0; i < int'(C_BEATS); i++) if (bus_idx == KW'(i)) beat_c = c_q[i];
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    j_d          = j_q;
    wb_cnt_d     = wb_cnt_q;
    wb_error_d   = wb_error_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    start_d      = 1'b0;
    fetch_done_d = 1'b0;
    bus_en       = 1'b0;
    bus_idx      = '0;
    push         = 1'b0;
    // The WAIT_FETCH cycle that sees oct_fetch is fetch beat 0.
    cur_j        = (state_q == StFetch) ? j_q : '0;

    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          for (int i = 0; i < int'(A_BEATS); i++) if (k_q == KW'(i)) a_d[i] = in_a;
          for (int i = 0; i < int'(B_BEATS); i++) if (k_q == KW'(i)) b_d[i] = in_b;
          for (int i = 0; i < int'(C_BEATS); i++) if (k_q == KW'(i)) c_d[i] = in_c;
          if (k_q == KW'(C_BEATS - 1)) begin
            k_d     = '0;
            state_d = StArm;
            bus_en  = 1'b1;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      StArm: begin
        if (oct_idle && room_ok) begin
          state_d = StStart;
          start_d = 1'b1;
        end else begin
          bus_en = 1'b1;
        end
      end
      StStart: begin
        state_d = StWaitFetch;
        bus_en  = 1'b1;
      end
      StWaitFetch, StFetch: begin
        if (oct_fetch) begin
          if (cur_j == KW'(C_BEATS - 1)) begin
            state_d      = StDone;
            fetch_done_d = 1'b1;
          end else begin
            state_d = StFetch;
            j_d     = cur_j + KW'(1);
            bus_en  = 1'b1;
            bus_idx = cur_j + KW'(1);
          end
        end else if (state_q == StFetch) begin
          // Fetch ended early: the Octet got a short tile.
          wb_error_d   = 1'b1;
          state_d      = StDone;
          fetch_done_d = 1'b1;
        end else begin
          bus_en = 1'b1;
        end
      end
      StDone: begin
        state_d  = StDrain;
        wb_cnt_d = '0;
      end
      StDrain: begin
        if (oct_write_back) begin
          if ((wb_cnt_q < WW'(C_BEATS)) && (!fifo_full || pop)) begin
            push = 1'b1;
          end else begin
            wb_error_d = 1'b1;
          end
          if (wb_cnt_q < WW'(C_BEATS)) wb_cnt_d = wb_cnt_q + WW'(1);
        end else if (wb_cnt_q != '0) begin
          state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase

    oct_a_d = bus_en ? beat_a : '0;
    oct_b_d = bus_en ? beat_b : '0;
    oct_c_d = bus_en ? beat_c : '0;
  end

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = oct_result;
      wptr_d = (wptr_q == PW'(RES_FIFO_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PW'(RES_FIFO_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q      <= StLoad;
      k_q          <= '0;
      j_q          <= '0;
      wb_cnt_q     <= '0;
      wb_error_q   <= 1'b0;
      start_q      <= 1'b0;
      fetch_done_q <= 1'b0;
      oct_a_q      <= '0;
      oct_b_q      <= '0;
      oct_c_q      <= '0;
      a_q          <= '{default: '0};
      b_q          <= '{default: '0};
      c_q          <= '{default: '0};
      mem_q        <= '{default: '0};
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      j_q          <= j_d;
      wb_cnt_q     <= wb_cnt_d;
      wb_error_q   <= wb_error_d;
      start_q      <= start_d;
      fetch_done_q <= fetch_done_d;
      oct_a_q      <= oct_a_d;
      oct_b_q      <= oct_b_d;
      oct_c_q      <= oct_c_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      mem_q        <= mem_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
    end
  end

  // in_ready is held low while reset is being applied.
  assign in_ready       = (state_q == StLoad) && !rstn;
  assign busy           = (state_q != StLoad);
  assign wb_error       = wb_error_q;
  assign oct_start      = start_q;
  assign oct_fetch_done = fetch_done_q;
  assign oct_a          = oct_a_q;
  assign oct_b          = oct_b_q;
  assign oct_c          = oct_c_q;

endmodule

// File: tb/tb_octet_dispatcher.sv
// Directed bench for octet_dispatcher: the bench plays both the upstream tile source and the
// Octet, and checks bus contents, pulses, result ordering, backpressure and error handling.
module tb_octet_dispatcher;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid, in_ready;
  logic [127:0] in_a, in_c;
  logic [63:0]  in_b;
  logic         oct_idle, oct_fetch, oct_compute, oct_write_back;
  logic [127:0] oct_result;
  logic         oct_start, oct_fetch_done;
  logic [127:0] oct_a, oct_c;
  logic [63:0]  oct_b;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         busy, wb_error;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  octet_dispatcher dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_c          (in_c),
    .oct_idle      (oct_idle),
    .oct_fetch     (oct_fetch),
    .oct_compute   (oct_compute),
    .oct_write_back(oct_write_back),
    .oct_result    (oct_result),
    .oct_start     (oct_start),
    .oct_fetch_done(oct_fetch_done),
    .oct_a         (oct_a),
    .oct_b         (oct_b),
    .oct_c         (oct_c),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .busy          (busy),
    .wb_error      (wb_error)
  );

  // Expected operand-bus contents for fetch beat j of a tile loaded with load_tile(base).
  function automatic logic [127:0] exp_a(int base, int j);
    return (j < 2) ? 128'(base + 'hA0 + j) : 128'(0);
  endfunction
  function automatic logic [63:0] exp_b(int base, int j);
    return (j < 4) ? 64'(base + 'hB0 + j) : 64'(0);
  endfunction
  function automatic logic [127:0] exp_c(int base, int j);
    return 128'(base + 'hC0 + j);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every beat carries A/B data; beats past A_BEATS/B_BEATS must be ignored by the DUT.
  task automatic load_tile(input int base);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_a = 128'(base + 'hA0 + k);
      in_b = 64'(base + 'hB0 + k);
      in_c = 128'(base + 'hC0 + k);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Waits for oct_start, then steps into WAIT_FETCH with the Octet busy.
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (oct_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      tick();
      oct_idle = 1'b0;
    end
  endtask

  // Emits n write-back beats, then one idle cycle so the DUT returns to LOAD.
  task automatic run_wb(input int n, input int base);
    for (int r = 0; r < n; r++) begin
      oct_write_back = 1'b1;
      oct_result = 128'(base + r);
      tick();
    end
    oct_write_back = 1'b0;
    tick();
    oct_idle = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready_during got=%0b exp=0", in_ready); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if ({oct_start, oct_fetch_done, out_valid, wb_error} !== 4'b0) begin
      failures++; $display("FAIL rst_flags got=%b exp=0000", {oct_start, oct_fetch_done, out_valid, wb_error});
    end
    checks++; if ({oct_a, oct_b, oct_c} !== '0) begin failures++; $display("FAIL rst_buses got=%h exp=0", {oct_a, oct_b, oct_c}); end
    rstn = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready_after got=%0b exp=1", in_ready); end
  endtask

  task automatic test_single_tile();
    int base;
    base = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_a = 128'('hA0 + k);
      in_b = 64'('hB0 + k);
      in_c = 128'('hC0 + k);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL load_in_ready k=%0d got=%0b exp=1", k, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    // ARM: beat 0 preloaded, no start yet
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL arm_busy got=%0b exp=1", busy); end
    checks++; if (oct_start !== 1'b0) begin failures++; $display("FAIL arm_start got=%0b exp=0", oct_start); end
    checks++; if (oct_a !== exp_a(base, 0) || oct_c !== exp_c(base, 0)) begin
      failures++; $display("FAIL arm_preload got a=%h c=%h exp a=%h c=%h", oct_a, oct_c, exp_a(base, 0), exp_c(base, 0));
    end
    tick();
    checks++; if (oct_start !== 1'b1) begin failures++; $display("FAIL start_pulse got=%0b exp=1", oct_start); end
    tick();
    oct_idle = 1'b0;
    checks++; if (oct_start !== 1'b0) begin failures++; $display("FAIL start_single got=%0b exp=0", oct_start); end
    tick();
    checks++; if (oct_c !== exp_c(base, 0) || oct_b !== exp_b(base, 0)) begin
      failures++; $display("FAIL wait_hold got b=%h c=%h exp b=%h c=%h", oct_b, oct_c, exp_b(base, 0), exp_c(base, 0));
    end
    for (int j = 0; j < 8; j++) begin
      oct_fetch = 1'b1;
      checks++;
      if (oct_a !== exp_a(base, j) || oct_b !== exp_b(base, j) || oct_c !== exp_c(base, j)) begin
        failures++;
        $display("FAIL fetch_beat j=%0d got a=%h b=%h c=%h exp a=%h b=%h c=%h", j, oct_a, oct_b, oct_c,
                 exp_a(base, j), exp_b(base, j), exp_c(base, j));
      end
      checks++; if (oct_fetch_done !== 1'b0) begin failures++; $display("FAIL early_done j=%0d got=1 exp=0", j); end
      tick();
    end
    oct_fetch = 1'b0;
    checks++; if (oct_fetch_done !== 1'b1) begin failures++; $display("FAIL fetch_done got=%0b exp=1", oct_fetch_done); end
    checks++; if ({oct_a, oct_b, oct_c} !== '0) begin failures++; $display("FAIL done_buses got=%h exp=0", {oct_a, oct_b, oct_c}); end
    tick();
    checks++; if (oct_fetch_done !== 1'b0) begin failures++; $display("FAIL done_once got=%0b exp=0", oct_fetch_done); end
  endtask

  task automatic test_write_back();
    int idx;
    idx = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      oct_write_back = (cyc < 8);
      oct_result = 128'('h100 + cyc);
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== 128'('h100 + idx)) begin
          failures++; $display("FAIL wb_data idx=%0d got=%h exp=%h", idx, out_data, 128'('h100 + idx));
        end
        idx++;
      end
      tick();
    end
    oct_write_back = 1'b0;
    oct_idle = 1'b1;
    checks++; if (idx !== 8) begin failures++; $display("FAIL wb_count got=%0d exp=8", idx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wb_to_load busy got=%0b exp=0", busy); end
    checks++; if (wb_error !== 1'b0) begin failures++; $display("FAIL wb_error got=%0b exp=0", wb_error); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit saw;
    out_ready = 1'b0;
    load_tile('h1000);
    wait_start(ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_start1 timeout got=0 exp=1"); end
    oct_fetch = 1'b1;
    repeat (8) tick();
    oct_fetch = 1'b0;
    tick();
    run_wb(8, 'h300);
    checks++; if (out_valid !== 1'b1 || out_data !== 128'('h300)) begin
      failures++; $display("FAIL bp_head got v=%0b d=%h exp v=1 d=300", out_valid, out_data);
    end
    load_tile('h2000);
    saw = 1'b0;
    repeat (5) begin
      if (oct_start === 1'b1) saw = 1'b1;
      tick();
    end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL bp_no_start got=1 exp=0"); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_arm_busy got=%0b exp=1", busy); end
    for (int p = 0; p < 8; p++) begin
      out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 128'('h300 + p) || oct_start !== 1'b0) begin
        failures++;
        $display("FAIL bp_pop p=%0d got v=%0b d=%h st=%0b exp v=1 d=%h st=0", p, out_valid, out_data,
                 oct_start, 128'('h300 + p));
      end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (oct_start !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_empty got st=%0b v=%0b exp st=0 v=0", oct_start, out_valid);
    end
    tick();
    checks++; if (oct_start !== 1'b1) begin failures++; $display("FAIL bp_start2 got=%0b exp=1", oct_start); end
    tick();
    oct_idle = 1'b0;
    oct_fetch = 1'b1;
    repeat (8) tick();
    oct_fetch = 1'b0;
    tick();
    out_ready = 1'b1;
    run_wb(8, 'h400);
    repeat (3) tick();
  endtask

  task automatic test_stalls();
    bit ok;
    for (int c = 0; c < 16; c++) begin
      in_valid = ((c % 2) == 0);
      if (in_valid) begin
        in_a = 128'('h3000 + 'hA0 + c / 2);
        in_b = 64'('h3000 + 'hB0 + c / 2);
        in_c = 128'('h3000 + 'hC0 + c / 2);
      end else begin
        in_a = 128'('hDEAD);
        in_b = 64'('hDEAD);
        in_c = 128'('hDEAD);
      end
      if (c == 14) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_still_load got=%0b exp=0", busy); end
      end
      if (c == 15) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_arm got=%0b exp=1", busy); end
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (oct_start !== 1'b1) begin failures++; $display("FAIL stall_start got=%0b exp=1", oct_start); end
    wait_start(ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_start timeout got=0 exp=1"); end
    for (int j = 0; j < 8; j++) begin
      oct_fetch = 1'b1;
      checks++;
      if (oct_a !== exp_a('h3000, j) || oct_c !== exp_c('h3000, j)) begin
        failures++;
        $display("FAIL stall_beat j=%0d got a=%h c=%h exp a=%h c=%h", j, oct_a, oct_c,
                 exp_a('h3000, j), exp_c('h3000, j));
      end
      tick();
    end
    oct_fetch = 1'b0;
    tick();
    out_ready = 1'b1;
    run_wb(8, 'h600);
    repeat (3) tick();
  endtask

  task automatic test_errors();
    bit ok;
    // Nine write-back beats into a non-draining FIFO: the ninth must be dropped.
    out_ready = 1'b0;
    load_tile('h4000);
    wait_start(ok);
    checks++; if (!ok) begin failures++; $display("FAIL err_start1 timeout got=0 exp=1"); end
    oct_fetch = 1'b1;
    repeat (8) tick();
    oct_fetch = 1'b0;
    tick();
    checks++; if (wb_error !== 1'b0) begin failures++; $display("FAIL err_pre got=%0b exp=0", wb_error); end
    run_wb(9, 'h200);
    checks++; if (wb_error !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL err_overrun got err=%0b busy=%0b exp err=1 busy=0", wb_error, busy);
    end
    for (int p = 0; p < 8; p++) begin
      out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 128'('h200 + p)) begin
        failures++; $display("FAIL err_pop p=%0d got v=%0b d=%h exp v=1 d=%h", p, out_valid, out_data, 128'('h200 + p));
      end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL err_ninth_dropped got=%0b exp=0", out_valid); end
    repeat (2) tick();
    checks++; if (wb_error !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", wb_error); end
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    checks++; if (wb_error !== 1'b0) begin failures++; $display("FAIL err_reset_clear got=%0b exp=0", wb_error); end

    // Fetch drops after five beats.
    out_ready = 1'b1;
    load_tile('h5000);
    wait_start(ok);
    checks++; if (!ok) begin failures++; $display("FAIL err_start2 timeout got=0 exp=1"); end
    oct_fetch = 1'b1;
    repeat (5) tick();
    oct_fetch = 1'b0;
    checks++; if (wb_error !== 1'b0 || oct_c !== exp_c('h5000, 5)) begin
      failures++; $display("FAIL err_short_pre got err=%0b c=%h exp err=0 c=%h", wb_error, oct_c, exp_c('h5000, 5));
    end
    tick();
    checks++; if (oct_fetch_done !== 1'b1 || wb_error !== 1'b1 || oct_c !== '0) begin
      failures++; $display("FAIL err_short got done=%0b err=%0b c=%h exp done=1 err=1 c=0", oct_fetch_done, wb_error, oct_c);
    end
    tick();
    checks++; if (oct_fetch_done !== 1'b0) begin failures++; $display("FAIL err_short_once got=1 exp=0"); end
    run_wb(8, 'h700);
    repeat (3) tick();
    checks++; if (wb_error !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL err_short_after got err=%0b busy=%0b exp err=1 busy=0", wb_error, busy);
    end
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    bit ok;
    load_tile('h6000);
    wait_start(ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_start timeout got=0 exp=1"); end
    oct_fetch = 1'b1;
    repeat (3) tick();
    checks++; if (oct_c !== exp_c('h6000, 3)) begin failures++; $display("FAIL mid_beat3 got=%h exp=%h", oct_c, exp_c('h6000, 3)); end
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    oct_fetch = 1'b0;
    oct_idle = 1'b1;
    #1;
    checks++; if ({oct_a, oct_b, oct_c} !== '0) begin failures++; $display("FAIL mid_buses got=%h exp=0", {oct_a, oct_b, oct_c}); end
    checks++; if ({oct_start, oct_fetch_done, out_valid, busy, wb_error} !== 5'b0) begin
      failures++; $display("FAIL mid_flags got=%b exp=00000", {oct_start, oct_fetch_done, out_valid, busy, wb_error});
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%0b exp=1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (oct_fetch_done !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL mid_quiet i=%0d got done=%0b busy=%0b exp 0 0", i, oct_fetch_done, busy);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_c = '0;
    oct_idle = 1'b1;
    oct_fetch = 1'b0;
    oct_compute = 1'b0;
    oct_write_back = 1'b0;
    oct_result = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_tile();
    test_write_back();
    test_backpressure();
    test_stalls();
    test_errors();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/octet_dispatcher.md
# octet_dispatcher

Tensor-core-level driver for one Octet compute unit. Collects one operand tile (A, B, C partial sums) from an upstream beat stream, starts the Octet, streams the tile into the Octet's buffers during its fetch phase, signals fetch completion, then captures the result beats the Octet emits during write-back into a small output FIFO. It sits between the tile scheduler and the Octet and is the counterpart that consumes the Octet's `idle/fetch/compute/write_back/result_out` status and produces its `start/fetch_done/a/b/c` inputs.

## Interface
Parameters:
- `A_DATA_WIDTH`, 128, A word width (two threadgroups × 2 × 32b).
- `B_DATA_WIDTH`, 64, B word width (shared activations).
- `C_DATA_WIDTH`, 128, C/result word width (8 × 16b).
- `A_BEATS`, 2, A words per tile.
- `B_BEATS`, 4, B words per tile.
- `C_BEATS`, 8, C words per tile; also the tile length `T` (all beat counters count 0..T-1).
- `RES_FIFO_DEPTH`, 8, result FIFO entries (≥ C_BEATS).

Ports:
- `clk` in 1 — single clock, all logic rising-edge.
- `rstn` in 1 — reset is synchronous and active-high: `rstn`=1 sampled on a `clk` edge resets the block.
- `in_valid` in 1, `in_ready` out 1 — upstream tile beat handshake; beat transfers when both are high.
- `in_a` in A_DATA_WIDTH, `in_b` in B_DATA_WIDTH, `in_c` in C_DATA_WIDTH — beat payload. Beat k stores `in_c` always, `in_a` only if k<A_BEATS, `in_b` only if k<B_BEATS.
- `oct_idle`, `oct_fetch`, `oct_compute`, `oct_write_back` in 1 — Octet phase status.
- `oct_result` in C_DATA_WIDTH — Octet `result_out`.
- `oct_start` out 1, `oct_fetch_done` out 1 — single-cycle pulses to the Octet.
- `oct_a` out A_DATA_WIDTH, `oct_b` out B_DATA_WIDTH, `oct_c` out C_DATA_WIDTH — registered operand buses to the Octet.
- `out_valid` out 1, `out_ready` in 1, `out_data` out C_DATA_WIDTH — result stream (FIFO head).
- `busy` out 1 — high in every state except LOAD.
- `wb_error` out 1 — sticky; cleared only by reset.

## Operation
- States: LOAD → ARM → START → WAIT_FETCH → FETCH → DONE → DRAIN → LOAD.
- LOAD: `in_ready`=1; beat counter `k` advances per accepted beat; after beat T-1 accepted → ARM. Staging: 2×A, 4×B, 8×C registers.
- ARM: wait until `oct_idle`=1 and FIFO free entries ≥ C_BEATS → START. Operand buses preload beat 0.
- START: `oct_start`=1 for exactly one cycle → WAIT_FETCH.
- WAIT_FETCH: hold beat 0 on buses; on first cycle `oct_fetch`=1 → FETCH with counter=0 that cycle.
- FETCH: in the j-th cycle of `oct_fetch`=1 (j=0..T-1), buses carry beat j: `oct_c`=C[j]; `oct_a`=A[j] if j<A_BEATS else 0; `oct_b`=B[j] if j<B_BEATS else 0. After j=T-1 → DONE. If `oct_fetch` drops before j=T-1: set `wb_error`, go DONE anyway.
- DONE: `oct_fetch_done`=1 one cycle, buses forced 0 → DRAIN.
- DRAIN: every cycle `oct_write_back`=1, push `oct_result` into FIFO, count beats. Exit to LOAD on first cycle `oct_write_back`=0 after ≥1 beat. More than C_BEATS beats, or push while FIFO full: drop beat, set `wb_error`.
- FIFO: depth RES_FIFO_DEPTH, pop when `out_valid & out_ready`; simultaneous push and pop when full allowed (count unchanged, no error). `out_data` valid only with `out_valid`.
- Operand buses are 0 in every state except WAIT_FETCH and FETCH (and ARM preload).

## Timing
- Reset: state LOAD, k=0, `in_ready`=0 during the reset cycle then 1; `oct_start`, `oct_fetch_done`, `out_valid`, `busy`, `wb_error`=0; buses 0; FIFO empty; staging cleared. Reset mid-tile aborts without pulsing any Octet signal.
- Minimum LOAD: T cycles. ARM→START: 1 cycle once conditions hold. `oct_start` to Octet fetch is Octet-defined.
- All Octet-facing outputs registered; beat j appears on buses in the same cycle the dispatcher observes the j-th `oct_fetch`=1 (preloaded/advanced on previous edge).
- `oct_fetch_done` asserted the cycle after FETCH beat T-1.
- Result push latency 0: `oct_result` sampled on the edge ending each write-back cycle; `out_valid` high next cycle.
- FIFO pointers wrap modulo RES_FIFO_DEPTH.

## Test plan
- Single tile: A={0xA0,0xA1}, B={0xB0..0xB3}, C={0xC0..0xC7}, Octet model fetches 8 cycles → buses show A0,A1,0..0 / B0..B3,0..0 / C0..C7; `oct_fetch_done` pulses once, cycle after C7.
- Write-back: model emits 8 results 0x100..0x107 with `out_ready`=1 → `out_data` sequence 0x100..0x107, `wb_error`=0, returns to LOAD.
- Backpressure: `out_ready`=0, first tile fills FIFO with 8 beats → second tile waits in ARM (no `oct_start`) until 8 pops, then starts.
- Upstream stalls: `in_valid` toggled 1,0,1,0… → 8 beats still stored in order; ARM reached after 16 cycles.
- Errors: model emits 9 write-back beats → 9th dropped, `wb_error`=1 stays high; model drops `oct_fetch` after 5 beats → `wb_error`=1, `oct_fetch_done` still pulses.
- Reset mid-FETCH at j=3 → next cycle all outputs 0, state LOAD, FIFO empty, no `oct_fetch_done`.
